// File: rtl/serial_add_seq.sv
// Bit-serial adder: one full-adder cell reused across WIDTH cycles.
// Operands enter on a valid/ready handshake; results leave on another.
module serial_add_seq #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             c_q;
    logic             cout_q;
    logic             ovf_q;
    logic             cell_s;
    logic             cell_c;
    logic             msb_step;

    assign cell_s   = a_q[0] ^ b_q[0] ^ c_q;
    assign cell_c   = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
    assign msb_step = (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (msb_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sum bits enter at the MSB end so bit 0 lands in place after WIDTH shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            cnt_q  <= '0;
            c_q    <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= in1;
                        b_q   <= in2;
                        c_q   <= carry_in;
                        cnt_q <= '0;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    sum_q <= {cell_s, sum_q[WIDTH-1:1]};
                    c_q   <= cell_c;
                    cnt_q <= cnt_q + 1'b1;
                    if (msb_step) begin
                        cout_q <= cell_c;
                        ovf_q  <= c_q ^ cell_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Bench for serial_add_seq: arithmetic model plus directed vectors,
// an 8-bit instance for directed cases and a 16-bit one for random runs.
module tb_serial_add_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv8, ir8, ci8, ov8, or8, co8, of8, bz8;
    logic [7:0]  a8, b8, s8;
    logic        iv16, ir16, ci16, ov16, or16, co16, of16, bz16;
    logic [15:0] a16, b16, s16;

    serial_add_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8),
        .in1(a8), .in2(b8), .carry_in(ci8),
        .out_valid(ov8), .out_ready(or8),
        .sum(s8), .carry_out(co8), .overflow(of8), .busy(bz8)
    );

    serial_add_seq #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv16), .in_ready(ir16),
        .in1(a16), .in2(b16), .carry_in(ci16),
        .out_valid(ov16), .out_ready(or16),
        .sum(s16), .carry_out(co16), .overflow(of16), .busy(bz16)
    );

    typedef struct {
        logic [63:0] s;
        logic        co;
        logic        of;
        int          acc;
    } exp_t;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    exp_t q8[$];
    exp_t q16[$];
    exp_t last8, last16, h8, h16;
    int   acc16_n = 0;
    int   prev16 = -1;
    int   gap16 = 0;
    int   gap_seq = 0;
    int   gap_seen = 0;

    // Golden result from plain integer addition of the operands.
    function automatic exp_t gold(input logic [63:0] a, input logic [63:0] b,
                                  input logic ci, input int w, input int acc);
        logic [64:0] t;
        exp_t        e;
        t     = {1'b0, a} + {1'b0, b} + {64'd0, ci};
        e.s   = t[63:0] & ((64'd1 << w) - 64'd1);
        e.co  = t[w];
        e.of  = (a[w-1] == b[w-1]) && (t[w-1] != a[w-1]);
        e.acc = acc;
        return e;
    endfunction

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk(input string nm, input int w, input int n,
                       input exp_t hd, input exp_t last,
                       input logic ir, input logic ov, input logic bz,
                       input logic [63:0] s, input logic co, input logic of);
        logic done_e;
        done_e = (n > 0) && ((cyc - hd.acc) >= w);
        cmp({nm, ".in_ready"}, 64'(ir), 64'(n == 0));
        cmp({nm, ".out_valid"}, 64'(ov), 64'(done_e));
        cmp({nm, ".busy"}, 64'(bz), 64'((n > 0) && !done_e));
        if (done_e) begin
            cmp({nm, ".sum"}, s, hd.s);
            cmp({nm, ".carry_out"}, 64'(co), 64'(hd.co));
            cmp({nm, ".overflow"}, 64'(of), 64'(hd.of));
        end else begin
            if (n == 0) begin
                cmp({nm, ".sum_hold"}, s, last.s);
            end
            cmp({nm, ".carry_hold"}, 64'(co), 64'(last.co));
            cmp({nm, ".ovf_hold"}, 64'(of), 64'(last.of));
        end
    endtask

    // Model: an operation is in flight while its queue entry exists.
    always @(posedge clk) begin
        logic idle8, idle16;
        cyc = cyc + 1;
        if (!rst_n) begin
            q8.delete();
            q16.delete();
            last8  = '{s: 64'd0, co: 1'b0, of: 1'b0, acc: 0};
            last16 = '{s: 64'd0, co: 1'b0, of: 1'b0, acc: 0};
            prev16 = -1;
        end else begin
            idle8  = (q8.size() == 0);
            idle16 = (q16.size() == 0);
            if (!idle8 && or8 && (cyc - 1 - q8[0].acc) >= 8) begin
                last8 = q8.pop_front();
            end
            if (!idle16 && or16 && (cyc - 1 - q16[0].acc) >= 16) begin
                last16 = q16.pop_front();
            end
            if (idle8 && iv8) begin
                q8.push_back(gold(64'(a8), 64'(b8), ci8, 8, cyc));
            end
            if (idle16 && iv16) begin
                q16.push_back(gold(64'(a16), 64'(b16), ci16, 16, cyc));
                if (prev16 >= 0) begin
                    gap16   = cyc - prev16;
                    gap_seq = gap_seq + 1;
                end
                prev16  = cyc;
                acc16_n = acc16_n + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (q8.size() > 0) h8 = q8[0];
            else h8 = last8;
            if (q16.size() > 0) h16 = q16[0];
            else h16 = last16;
            chk("w8", 8, q8.size(), h8, last8, ir8, ov8, bz8, 64'(s8), co8, of8);
            chk("w16", 16, q16.size(), h16, last16, ir16, ov16, bz16, 64'(s16), co16, of16);
            if (gap_seq != gap_seen) begin
                gap_seen = gap_seq;
                cmp("w16.spacing", 64'(gap16), 64'd18);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic [7:0] es, input logic eco, input logic eof,
                        input string nm);
        int n;
        or8 = 1'b1;
        iv8 = 1'b1;
        a8  = a;
        b8  = b;
        ci8 = ci;
        step();
        iv8 = 1'b0;
        n = 0;
        while (!ov8 && n < 20) begin
            step();
            n++;
        end
        cmp({nm, ".latency"}, 64'(n), 64'd8);
        cmp({nm, ".sum"}, 64'(s8), 64'(es));
        cmp({nm, ".carry_out"}, 64'(co8), 64'(eco));
        cmp({nm, ".overflow"}, 64'(of8), 64'(eof));
        step();
    endtask

    task automatic reset_vals(input string nm);
        cmp({nm, ".ir8"}, 64'(ir8), 64'd1);
        cmp({nm, ".ov8"}, 64'(ov8), 64'd0);
        cmp({nm, ".bz8"}, 64'(bz8), 64'd0);
        cmp({nm, ".s8"}, 64'(s8), 64'd0);
        cmp({nm, ".co8"}, 64'(co8), 64'd0);
        cmp({nm, ".of8"}, 64'(of8), 64'd0);
    endtask

    initial begin
        int n;
        iv8 = 0; a8 = 0; b8 = 0; ci8 = 0; or8 = 0;
        iv16 = 0; a16 = 0; b16 = 0; ci16 = 0; or16 = 0;
        rst_n = 1'b0;
        repeat (2) step();
        reset_vals("por");
        cmp("por.ir16", 64'(ir16), 64'd1);
        cmp("por.s16", 64'(s16), 64'd0);
        rst_n = 1'b1;
        step();

        // Abandon an operation three cycles into RUN.
        iv8 = 1'b1; a8 = 8'hF0; b8 = 8'h0F; ci8 = 1'b0;
        step();
        iv8 = 1'b0;
        repeat (3) step();
        cmp("midrun.busy", 64'(bz8), 64'd1);
        rst_n = 1'b0;
        #1;
        reset_vals("midrun");
        step();
        rst_n = 1'b1;
        step();

        run8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, "after_rst");
        run8(8'h3C, 8'h55, 1'b0, 8'h91, 1'b0, 1'b1, "pos_ovf");
        run8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, "wrap");
        run8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "neg_ovf");
        run8(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, "cin_ovf");

        // Result held under backpressure while new operands are offered.
        or8 = 1'b0;
        iv8 = 1'b1; a8 = 8'h12; b8 = 8'h34; ci8 = 1'b0;
        step();
        iv8 = 1'b0;
        n = 0;
        while (!ov8 && n < 20) begin
            step();
            n++;
        end
        cmp("bp.latency", 64'(n), 64'd8);
        iv8 = 1'b1; a8 = 8'hAA; b8 = 8'hAA; ci8 = 1'b1;
        repeat (20) step();
        cmp("bp.sum", 64'(s8), 64'h46);
        cmp("bp.in_ready", 64'(ir8), 64'd0);
        cmp("bp.out_valid", 64'(ov8), 64'd1);
        iv8 = 1'b0;
        or8 = 1'b1;
        step();
        cmp("bp.rel_ir", 64'(ir8), 64'd1);
        cmp("bp.rel_ov", 64'(ov8), 64'd0);
        cmp("bp.rel_sum", 64'(s8), 64'h46);

        // Back-to-back random operations on the 16-bit instance.
        or16 = 1'b1;
        iv16 = 1'b1;
        a16  = 16'($urandom);
        b16  = 16'($urandom);
        ci16 = 1'($urandom);
        n = 0;
        while (acc16_n < 1000 && n < 20000) begin
            step();
            a16  = 16'($urandom);
            b16  = 16'($urandom);
            ci16 = 1'($urandom);
            n++;
        end
        iv16 = 1'b0;
        cmp("rnd.accepted", 64'(acc16_n), 64'd1000);
        n = 0;
        while (q16.size() > 0 && n < 100) begin
            step();
            n++;
        end
        cmp("rnd.drained", 64'(q16.size()), 64'd0);
        cmp("rnd.gaps", 64'(gap_seq), 64'd999);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_add_seq.md
Name: serial_add_seq

Overview:
- Bit-serial addition sequencer: time-multiplexes one 1-bit full-adder cell (sum = a^b^c, carry = majority) across WIDTH cycles to add two WIDTH-bit operands plus carry_in.
- Captures operands on a valid/ready handshake and walks the cell LSB to MSB, holding the running carry in a flop.
- Presents the sum, carry_out and signed overflow on an output valid/ready handshake.
- Used where area matters more than latency, in front of or in place of a ripple adder built from chained full adders.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), bit-index counter width; derived, not overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operands and carry_in are valid this cycle.
- in_ready  output  1  block can accept operands (high only in IDLE).
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B.
- carry_in  input  1  initial carry into bit 0.
- out_valid  output  1  result is valid (high only in DONE).
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  A + B + carry_in, modulo 2^WIDTH.
- carry_out  output  1  carry out of bit WIDTH-1.
- overflow  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
- busy  output  1  high in RUN.

Behaviour:
- Reset (rst_n low, any time, asynchronous):
  - state=IDLE, bit counter=0, carry flop=0.
  - Operand shift registers and sum register cleared to 0.
  - in_ready=1, out_valid=0, busy=0, sum=0, carry_out=0, overflow=0.
  - A reset in RUN or DONE abandons the operation and drops the result; after rst_n rises, the next edge behaves as IDLE.
- States IDLE, RUN, DONE; one-hot or binary encoding is implementer's choice.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, capture in1, in2 and carry_in into the A/B shift registers and carry flop, clear counter to 0, go to RUN.
  - in_valid=0: stay.
- RUN (exactly WIDTH cycles):
  - in_ready=0, busy=1.
  - Each edge: feed the cell A[0], B[0] and the carry flop; shift the cell sum bit into the sum register from the MSB end (right shift); carry flop <= cell carry; shift A and B right by 1; counter increments.
  - On the edge where counter==WIDTH-1 (the MSB step):
    - record overflow = carry flop value before the update XOR cell carry;
    - carry_out <= cell carry;
    - go to DONE.
  - Operand and control inputs are ignored in RUN.
- DONE:
  - out_valid=1; sum, carry_out and overflow are stable until the handshake.
  - On an edge with out_ready=1, go to IDLE; outputs keep their values but out_valid drops.
  - out_ready=0: hold indefinitely with no change.
  - in_valid in DONE is not accepted (in_ready=0).
- Latency and throughput:
  - Accept edge to out_valid=1 is WIDTH+1 edges (1 capture + WIDTH compute).
  - Maximum throughput is one result per WIDTH+2 cycles with out_ready tied high.
  - No pipelining or back-to-back overlap.
- Arithmetic: unsigned sum modulo 2^WIDTH. carry_out is the unsigned carry. overflow applies only to the signed interpretation.
- Outputs sum, carry_out and overflow are registered. out_valid, in_ready and busy are decoded from state only, with no combinational path from inputs.

Test Plan:
- Reset mid-RUN:
  - Stimulus: WIDTH=8; accept 0xF0+0x0F; assert rst_n=0 after 3 RUN cycles, then release.
  - Required response: all outputs return to reset values immediately; in_ready=1; a subsequent 0x01+0x01, cin=0 yields sum=0x02.
- Basic add with wrap:
  - Stimulus: WIDTH=8, in1=0x3C, in2=0x55, carry_in=0.
  - Required response: out_valid rises exactly 9 edges after accept; sum=0x91, carry_out=0, overflow=1 (60+85 exceeds +127).
- Full wrap-around:
  - Stimulus: in1=0xFF, in2=0x00, carry_in=1.
  - Required response: sum=0x00, carry_out=1, overflow=0.
- Negative overflow:
  - Stimulus: in1=0x80, in2=0x80, carry_in=0.
  - Required response: sum=0x00, carry_out=1, overflow=1.
- Backpressure and ignored input:
  - Stimulus: hold out_ready=0 for 20 cycles in DONE while driving in_valid=1 with new operands.
  - Required response: outputs stable, in_ready=0, no capture; out_ready=1 then returns to IDLE and in_ready=1 next cycle.
- Randomized back-to-back:
  - Stimulus: WIDTH=16, 1000 random operand/cin triples with in_valid and out_ready held high.
  - Required response: every result matches the golden model {carry_out,sum}=in1+in2+cin; result spacing is exactly 18 cycles.
